muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit beside the combinational ALU for MULT/MULTU/DIV/DIVU,

---
 rtl/muldiv_if.sv | 18 +
 rtl/muldiv_unit.sv | 94 +++++++++
 tb/tb_muldiv_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: controller-side request, MTHI/MTLO write and HI/LO result signals of the multiply/divide unit
`timescale 1ns/1ps
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, A, B, hi_we, lo_we, wdata, input busy, done, dz, hi, lo);
  modport slave  (input start, op, A, B, hi_we, lo_we, wdata, output busy, done, dz, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider owning the HI/LO pair
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t             state, nxt;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH-1:0]   hi_q, lo_q, mag_a, mag_b, div_q, div_r, fin_hi, fin_lo;
  logic [WIDTH:0]     mul_sum, div_sh, div_df;
  logic               dz_q, is_div, is_signed, a_neg, b_neg, b_zero, last;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s & x[WIDTH-1]) ? -x : x;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (bus.start ? CALC : IDLE) :
          state == CALC ? (last ? FINISH : CALC) : IDLE;
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == FINISH;
  end
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign b_zero    = b_q == '0;
  assign mag_a     = mag(a_q, is_signed);
  assign mag_b     = mag(b_q, is_signed);
  assign last      = state == CALC && count == CW'(WIDTH - 1);
  // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  // divide:   acc = {partial remainder, dividend/quotient bits}, shifted left each step
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_df  = div_sh - {1'b0, mag_b};
    acc_nxt = is_div ? {div_df[WIDTH] ? div_sh[WIDTH-1:0] : div_df[WIDTH-1:0], acc[WIDTH-2:0], ~div_df[WIDTH]}
                     : {mul_sum, acc[WIDTH-1:1]};
  end
  // sign fix-up is applied to the final iteration so HI/LO are valid during FINISH
  always_comb begin
    prod   = (a_neg ^ b_neg) ? -acc_nxt : acc_nxt;
    div_q  = (a_neg ^ b_neg) ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    div_r  = a_neg ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    fin_hi = !is_div ? prod[2*WIDTH-1:WIDTH] : b_zero ? a_q : div_r;
    fin_lo = !is_div ? prod[WIDTH-1:0] : b_zero ? '1 : div_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dz_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.hi_we) hi_q <= bus.wdata;
      if (bus.lo_we) lo_q <= bus.wdata;
      if (bus.start) begin
        op_q  <= bus.op;
        a_q   <= bus.A;
        b_q   <= bus.B;
        acc   <= {{WIDTH{1'b0}}, bus.op[1] ? mag(bus.A, ~bus.op[0]) : mag(bus.B, ~bus.op[0])};
        count <= '0;
        dz_q  <= 1'b0;
      end
    end else if (state == CALC) begin
      acc   <= acc_nxt;
      count <= count + 1'b1;
      if (last) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
        dz_q <= is_div & b_zero;
      end
    end
  end
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  assign bus.dz = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed scoreboard bench for muldiv_unit against an arithmetic model
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int W = 32;
  typedef struct {int cyc; logic [31:0] hi; logic [31:0] lo; logic dz;} res_t;
  typedef struct {int cyc; int kind; logic [31:0] exp;} probe_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic fin = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  res_t sbq[$];
  probe_t pq[$];
  muldiv_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] probe_act(input int k);
    return k == 0 ? 32'(bus.busy) : k == 1 ? 32'(bus.done) : k == 2 ? 32'(bus.dz) : k == 3 ? bus.hi : bus.lo;
  endfunction
  function automatic string probe_name(input int k);
    return k == 0 ? "busy" : k == 1 ? "done" : k == 2 ? "dz" : k == 3 ? "hi_hold" : "lo_hold";
  endfunction
  // reference: plain 64-bit arithmetic; SV division truncates and % follows the dividend sign
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic d);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    d = 1'b0;
    h = '0;
    l = '0;
    if (op[1] && b == 0) begin
      l = '1;
      h = a;
      d = 1'b1;
    end else if (op == 2'd0) begin
      p = sa * sb;
      {h, l} = p;
    end else if (op == 2'd1) begin
      u = {32'b0, a} * {32'b0, b};
      {h, l} = u;
    end else if (op == 2'd2) begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end else begin
      l = a / b;
      h = a % b;
    end
  endfunction
  always @(negedge clk) begin
    res_t r;
    if (bus.done === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_done", 32'(bus.done), 32'd0);
      else begin
        r = sbq.pop_front();
        chk("done_cycle", cyc, r.cyc);
        chk("hi", bus.hi, r.hi);
        chk("lo", bus.lo, r.lo);
        chk("dz", 32'(bus.dz), 32'(r.dz));
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
      chk("missing_done", 32'(bus.done), 32'd1);
      void'(sbq.pop_front());
    end
    for (int i = pq.size() - 1; i >= 0; i--)
      if (pq[i].cyc == cyc) begin
        chk(probe_name(pq[i].kind), probe_act(pq[i].kind), pq[i].exp);
        pq.delete(i);
      end
    if (fin) begin
      chk("scoreboard_drained", sbq.size(), 32'd0);
      chk("probes_drained", pq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic probe(input int c, input int k, input logic [31:0] e);
    pq.push_back('{c, k, e});
  endtask
  task automatic wait_idle;
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      tick;
      n++;
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l;
    logic d;
    wait_idle;
    bus.start = 1'b1;
    bus.op = op;
    bus.A = a;
    bus.B = b;
    model(op, a, b, h, l, d);
    sbq.push_back('{cyc + W + 1, h, l, d});
    m_hi = h;
    m_lo = l;
    tick;
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.A = $urandom;
    bus.B = $urandom;
  endtask
  function automatic logic [31:0] pick();
    int s = $urandom_range(0, 5);
    return s == 0 ? 32'd0 : s == 1 ? 32'hFFFF_FFFF : s == 2 ? 32'h8000_0000 : s == 3 ? 32'($urandom_range(1, 20)) : $urandom;
  endfunction
  initial begin
    int c0;
    logic [31:0] ph, pl;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = '0;
    bus.A = '0;
    bus.B = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    tick;
    tick;
    for (int k = 0; k < 5; k++) probe(cyc, k, 32'd0);
    tick;
    rst = 1'b0;
    tick;
    c0 = cyc;
    probe(c0, 0, 32'd0);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 1; i <= W + 1; i++) probe(c0 + i, 0, 32'd1);
    probe(c0 + W + 2, 0, 32'd0);
    issue(2'd0, 32'hFFFF_FFFD, 32'd7);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    issue(2'd3, 32'd100, 32'd0);
    wait_idle;
    probe(cyc, 2, 32'd1);
    issue(2'd1, $urandom, $urandom);
    probe(cyc, 2, 32'd0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'd3, 32'h8000_0000, 32'd3);
    wait_idle;
    ph = m_hi;
    pl = m_lo;
    issue(2'd1, $urandom, $urandom);
    repeat (5) tick;
    bus.start = 1'b1;
    bus.op = 2'd2;
    bus.B = 32'd0;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    probe(cyc + 1, 3, ph);
    probe(cyc + 1, 4, pl);
    tick;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    wait_idle;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    probe(cyc + 1, 3, 32'h0000_1234);
    probe(cyc + 1, 4, m_lo);
    tick;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5678;
    probe(cyc + 1, 3, 32'h0000_1234);
    probe(cyc + 1, 4, 32'h0000_5678);
    tick;
    bus.lo_we = 1'b0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_ABCD;
    probe(cyc + 1, 3, 32'h0000_ABCD);
    issue(2'd0, $urandom, $urandom);
    bus.hi_we = 1'b0;
    wait_idle;
    issue(2'd0, pick(), pick());
    repeat (9) tick;
    rst = 1'b1;
    sbq.delete();
    for (int k = 0; k < 5; k++) probe(cyc, k, 32'd0);
    probe(cyc + 1, 1, 32'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    issue(2'd3, 32'd1000, 32'd7);
    repeat (40) issue(2'($urandom), pick(), pick());
    wait_idle;
    repeat (3) tick;
    fin = 1'b1;
    repeat (5) tick;
    $display("FAIL no_summary: monitor did not finish");
    $fatal(1);
  end
endmodule
